// File: rtl/pcm_i2s_tx.sv
// PCM-to-I2S serializer: pops words from an upstream FIFO and emits them as
// left/right I2S slots with a divided bit clock, MSB first, ws leading by one sck.
module pcm_i2s_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  fifo_rd_en_o,
    output logic                  i2s_sck_o,
    output logic                  i2s_ws_o,
    output logic                  i2s_sd_o,
    output logic                  underrun_o,
    input  logic                  underrun_clr_i,
    output logic                  busy_o
);

    localparam int              CW         = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   BIT_LAST   = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]   BIT_PRELSB = CW'(DATA_WIDTH - 2);
    localparam logic [7:0]      DIV_LAST   = 8'(CLK_DIV - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [7:0]            r_div;
    logic                  r_sck;
    logic                  r_ws;
    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_underrun;
    logic                  r_enable;
    logic                  r_first;

    state_t                w_state_nxt;
    logic [7:0]            w_div_nxt;
    logic                  w_sck_nxt;
    logic                  w_ws_nxt;
    logic [CW-1:0]         w_bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_first_nxt;
    logic                  w_underrun_set;

    logic w_tick;
    logic w_fall;
    logic w_wrap;
    logic w_stop;
    logic w_load;

    // Slot-boundary decode; enable is taken from its registered copy so the
    // pop strobe depends only on flops and the FIFO empty flag.
    assign w_tick = (r_state == ST_RUN) && (r_div == DIV_LAST);
    assign w_fall = w_tick && r_sck;
    assign w_wrap = w_fall && (r_bit_cnt == BIT_LAST);
    assign w_stop = w_wrap && !r_ws && !r_first && !r_enable;
    assign w_load = w_wrap && !w_stop;

    assign fifo_rd_en_o = w_load && !fifo_empty_i && !reset_i;

    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_sck_nxt      = r_sck;
        w_ws_nxt       = r_ws;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_first_nxt    = r_first;
        w_underrun_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable_i) begin
                    w_state_nxt   = ST_RUN;
                    w_div_nxt     = 8'd0;
                    w_sck_nxt     = 1'b0;
                    w_ws_nxt      = 1'b0;
                    w_bit_cnt_nxt = BIT_LAST;
                    w_first_nxt   = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_tick) begin
                    w_div_nxt = 8'd0;
                    w_sck_nxt = ~r_sck;
                end else begin
                    w_div_nxt = r_div + 8'd1;
                end
                if (w_stop) begin
                    w_state_nxt   = ST_IDLE;
                    w_sck_nxt     = 1'b0;
                    w_ws_nxt      = 1'b0;
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = '0;
                end else if (w_load) begin
                    w_bit_cnt_nxt  = '0;
                    w_first_nxt    = 1'b0;
                    w_shift_nxt    = fifo_empty_i ? '0 : fifo_rd_data_i;
                    w_underrun_set = fifo_empty_i;
                end else if (w_fall) begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    w_shift_nxt   = {r_shift[DATA_WIDTH-2:0], 1'b0};
                    // ws flips as the LSB goes out, one sck ahead of the next MSB
                    if (r_bit_cnt == BIT_PRELSB) begin
                        w_ws_nxt = ~r_ws;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_div      <= 8'd0;
            r_sck      <= 1'b0;
            r_ws       <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_underrun <= 1'b0;
            r_enable   <= 1'b0;
            r_first    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_sck      <= w_sck_nxt;
            r_ws       <= w_ws_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_underrun <= w_underrun_set | (r_underrun & ~underrun_clr_i);
            r_enable   <= enable_i;
            r_first    <= w_first_nxt;
        end
    end

    assign i2s_sck_o  = r_sck;
    assign i2s_ws_o   = r_ws;
    assign i2s_sd_o   = r_shift[DATA_WIDTH-1];
    assign underrun_o = r_underrun;
    assign busy_o     = (r_state == ST_RUN);

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Bench for pcm_i2s_tx: FIFO model plus an arithmetic frame-timing reference
// that predicts sck/ws/sd/busy/rd_en/underrun for every clock of a stream.
module tb_pcm_i2s_tx;

    localparam int DW    = 16;
    localparam int CD    = 2;
    localparam int BITP  = 2 * CD;
    localparam int SLOT  = BITP * DW;
    localparam int FRAME = 2 * SLOT;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          fe;
    logic          clr;
    logic [DW-1:0] fd;
    logic          rd_en;
    logic          sck;
    logic          ws;
    logic          sd;
    logic          und;
    logic          busy;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            rd_k_q[$];
    int            checks = 0;
    int            errors = 0;
    int            pops   = 0;

    always #5 clk = ~clk;

    pcm_i2s_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .enable_i       (en),
        .fifo_empty_i   (fe),
        .fifo_rd_data_i (fd),
        .fifo_rd_en_o   (rd_en),
        .i2s_sck_o      (sck),
        .i2s_ws_o       (ws),
        .i2s_sd_o       (sd),
        .underrun_o     (und),
        .underrun_clr_i (clr),
        .busy_o         (busy)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] obs_vec();
        return {26'd0, busy, sck, ws, sd, rd_en, und};
    endfunction

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic fifo_update();
        fe = (fifo_q.size() == 0);
        fd = fe ? '0 : fifo_q[0];
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_update();
    endtask

    // One clock: FIFO pops on the edge where rd_en was high; returns at negedge.
    task automatic tick();
        logic          p;
        logic [DW-1:0] dummy;
        p = rd_en;
        @(posedge clk);
        #1;
        if (p) begin
            dummy = fifo_q.pop_front();
            pops++;
            fifo_update();
        end
        @(negedge clk);
    endtask

    task automatic idle_prep();
        en  = 1'b0;
        clr = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        fifo_update();
        tick();
        clr = 1'b0;
        tick();
        check("idle", 0, obs_vec(), 32'd0);
    endtask

    // Streams the words in exp_q; enable is dropped after observation drop_k.
    task automatic run_window(input int n_obs, input int drop_k, input int clr_a, input int clr_b);
        int            s_frames;
        int            last;
        int            np;
        int            e;
        int            m;
        int            n;
        int            exp_pops;
        logic          u;
        logic          set;
        logic          eb, es, ew, ed, er;
        logic [DW-1:0] word;
        np = exp_q.size();
        s_frames = 1;
        while (2 * CD + s_frames * FRAME < drop_k + 2) s_frames++;
        last = 2 * CD + s_frames * FRAME;
        u = 1'b0;
        pops = 0;
        rd_k_q.delete();
        en = 1'b1;
        tick();
        for (int k = 0; k < n_obs; k++) begin
            eb = (k < last);
            es = eb && (((k / CD) % 2) == 1);
            ew = eb && (((k / SLOT) % 2) == 1);
            ed = 1'b0;
            if (eb && k >= 2 * CD) begin
                m = (k - 2 * CD) / BITP;
                n = m / DW;
                word = (n < np) ? exp_q[n] : '0;
                ed = word[DW - 1 - (m % DW)];
            end
            e = k + 1;
            er = (e >= 2 * CD) && (e < last) && (((e - 2 * CD) % SLOT) == 0) && (((e - 2 * CD) / SLOT) < np);
            check("frame", k, obs_vec(), {26'd0, eb, es, ew, ed, er, u});
            if (rd_en) rd_k_q.push_back(k);
            if (k == drop_k) en = 1'b0;
            clr = (k == clr_a) || (k == clr_b);
            set = (e >= 2 * CD) && (e < last) && (((e - 2 * CD) % SLOT) == 0) && (((e - 2 * CD) / SLOT) >= np);
            u = set | (u & ~clr);
            tick();
        end
        clr = 1'b0;
        en  = 1'b0;
        exp_pops = (np < 2 * s_frames) ? np : 2 * s_frames;
        check("pop_count", 0, 32'(pops), 32'(exp_pops));
        if (rd_k_q.size() > 0) check("first_rd_en", 0, 32'(rd_k_q[0]), 32'(2 * CD - 1));
        for (int i = 1; i < rd_k_q.size(); i++)
            check("rd_en_gap", i, 32'(rd_k_q[i] - rd_k_q[i-1]), 32'(SLOT));
    endtask

    initial begin
        int np;
        int f;
        int dk;
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        fifo_update();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_reset", 0, obs_vec(), 32'd0);
        rst = 1'b0;
        tick();
        check("after_reset", 0, obs_vec(), 32'd0);

        // Two-word frame, enable pulsed for one cycle
        idle_prep();
        push_word(16'hA5F0);
        push_word(16'h1234);
        run_window(140, 0, -1, -1);

        // Single word with enable held through the right slot: underrun on right load
        idle_prep();
        push_word(16'h8001);
        run_window(140, 100, 135, -1);

        // Clear coinciding with a new underrun, then a clear on its own
        idle_prep();
        run_window(270, 150, 3, 20);

        // Enable dropped in the middle of the second left slot
        idle_prep();
        for (int i = 0; i < 4; i++) push_word(16'($urandom));
        run_window(270, 2 * CD + FRAME + 20, -1, -1);

        // Eight-word stream
        idle_prep();
        for (int i = 0; i < 8; i++) push_word(16'($urandom));
        run_window(530, 2 * CD + 3 * FRAME + 20, -1, -1);

        // Randomized word counts and stop points
        for (int r = 0; r < 3; r++) begin
            idle_prep();
            np = $urandom_range(1, 5);
            f  = $urandom_range(1, 3);
            for (int i = 0; i < np; i++) push_word(16'($urandom));
            dk = 2 * CD + (f - 1) * FRAME + $urandom_range(10, 100);
            run_window(2 * CD + f * FRAME + 8, dk, -1, -1);
        end

        // Mid-slot reset held three cycles
        idle_prep();
        for (int i = 0; i < 3; i++) push_word(16'($urandom));
        pops = 0;
        en = 1'b1;
        tick();
        repeat (40) tick();
        check("pre_reset_pops", 0, 32'(pops), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) en = 1'b0;
            #1;
            check("reset_rd_en", i, {31'd0, rd_en}, 32'd0);
            tick();
            check("reset_hold", i, obs_vec(), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("post_reset", 0, obs_vec(), 32'd0);
        check("reset_pops", 0, 32'(pops), 32'd1);

        // Reset landing on the cycle of a pending pop suppresses it
        idle_prep();
        push_word(16'h5A5A);
        push_word(16'hC3C3);
        pops = 0;
        en = 1'b1;
        tick();
        repeat (2 * CD - 1 + SLOT) tick();
        check("pending_rd_en", 0, {31'd0, rd_en}, 32'd1);
        rst = 1'b1;
        #1;
        check("reset_gates_rd_en", 0, {31'd0, rd_en}, 32'd0);
        en = 1'b0;
        tick();
        check("reset_no_pop", 0, 32'(pops), 32'd1);
        check("reset_fifo_left", 0, 32'(fifo_q.size()), 32'd1);
        rst = 1'b0;
        tick();
        check("post_reset2", 0, obs_vec(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcm_i2s_tx.md
PCM_I2S_TX -- requirements
Module: pcm_i2s_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving PCM word width and I2S slot length in bits; legal range 8..32.
REQ-002 SHALL have parameter CLK_DIV, default 4, giving clock_i cycles per sck half-period; legal range 1..255.
REQ-003 SHALL have port clock_i, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port enable_i, input, 1, a level that starts and stops streaming.
REQ-006 SHALL have port fifo_empty_i, input, 1, the upstream FIFO empty flag.
REQ-007 SHALL have port fifo_rd_data_i, input, DATA_WIDTH, the FIFO head word; it is valid combinationally whenever fifo_empty_i=0.
REQ-008 SHALL have port fifo_rd_en_o, output, 1, the FIFO pop strobe.
REQ-009 SHALL have port i2s_sck_o, output, 1, the bit clock.
REQ-010 SHALL have port i2s_ws_o, output, 1, word select: 0 for left, 1 for right.
REQ-011 SHALL have port i2s_sd_o, output, 1, serial data, MSB first.
REQ-012 SHALL have port underrun_o, output, 1, a sticky flag set when a slot was loaded while the FIFO was empty.
REQ-013 SHALL have port underrun_clr_i, input, 1, which clears underrun_o.
REQ-014 SHALL have port busy_o, output, 1, high while the state is RUN.

Function
REQ-015 SHALL implement two states, IDLE and RUN; IDLE->RUN on the edge where enable_i=1 is sampled in IDLE, with the divider cleared to 0, sck=0, ws=0 and bit_cnt=DATA_WIDTH-1.
REQ-016 SHALL count the divider 0..CLK_DIV-1 in RUN; a tick occurs on the edge where the count equals CLK_DIV-1, the count wraps to 0 and i2s_sck_o toggles; sck period = 2*CLK_DIV clocks.
REQ-017 SHALL treat a tick with sck=1 (a falling event) as the only point where ws, sd, bit_cnt and the shift register change.
REQ-018 SHALL handle each falling event as follows: bit_cnt increments modulo DATA_WIDTH; on a wrap to 0 a new slot is loaded and sd=MSB; otherwise the register shifts left and sd=next bit.
REQ-019 SHALL toggle ws on the falling event that drives the slot's LSB (bit_cnt becomes DATA_WIDTH-1), so that ws leads the MSB by exactly one sck (I2S format).
REQ-020 SHALL, on a slot load with fifo_empty_i=0, load fifo_rd_data_i and assert fifo_rd_en_o for exactly that one cycle (the cycle whose closing edge performs the load).
REQ-021 SHALL derive fifo_rd_en_o from registered state and fifo_empty_i only, and SHALL never assert it while fifo_empty_i=1.
REQ-022 SHALL, on a slot load with fifo_empty_i=1, load all-zeros, issue no pop, and set underrun_o on that edge.
REQ-023 SHALL sample enable_i only at left-slot loads (wrap with ws=0); if enable_i=0 there, the block goes to IDLE with no load and no pop, so frames always complete as left+right pairs.
REQ-024 SHALL clear underrun_o with underrun_clr_i=1; a set and a clear on the same edge leave underrun_o=1.
REQ-025 SHALL hold i2s_sck_o=0, i2s_ws_o=0 and i2s_sd_o=0 in IDLE, with the divider frozen.
REQ-026 SHALL, with CLK_DIV=c, assert the first fifo_rd_en_o in the cycle ending at edge 2c after entering RUN, and then every 2c*DATA_WIDTH clocks while streaming.

Reset
REQ-027 SHALL, while reset_i=1 at an edge, force state IDLE, all counters 0, shift register 0, and all outputs 0 (underrun_o and busy_o included); fifo_rd_en_o SHALL be 0 during reset.
REQ-028 SHALL give reset_i priority over enable_i, underrun_clr_i and any in-progress slot; a mid-frame reset abandons the frame without a pop.

Verification (DATA_WIDTH=16, CLK_DIV=2)
REQ-029 SHALL cover a mid-slot reset held 3 cycles -> the next edge shows busy=0, sck=ws=sd=0 and no rd_en pulse.
REQ-030 SHALL cover a FIFO holding 0xA5F0,0x1234 with enable pulsed for 1 cycle -> left slot 1010010111110000 with ws=0, right slot 0x1234 with ws=1, two rd_en pulses 64 clocks apart, and busy=0 after 128 sck-related clocks.
REQ-031 SHALL cover a FIFO holding only 0x8001 with enable held -> left=0x8001, right=0x0000, underrun_o=1 from the right-slot load edge, and exactly one rd_en.
REQ-032 SHALL cover underrun_clr_i on the same edge as a new underrun -> underrun_o stays 1; a clear alone -> 0 on the next edge.
REQ-033 SHALL cover enable dropped mid-left-slot -> the right slot completes, the next left load does not occur, state returns to IDLE, and outputs are 0.
REQ-034 SHALL cover streaming of 8 words -> rd_en every 64 clocks, ws period 128 clocks, and sd matching the words MSB-first, one sck after each ws edge.
